// File: rtl/mc_control_fsm_pkg.sv
// mc_ctrl_pkg
// Shared encodings for the multi-cycle MIPS main control FSM:
//   state_t   - 4-bit controller state codes (FETCH..JUMP, FAULT)
//   OP_*      - instruction opcodes found in IR[31:26]
//   ALUOP_*   - operation requests handed to the ALU decoder
//   PCSRC_*   - next-PC source select
//   SRCB_*    - ALU B-operand select
// Helper functions decide opcode legality and the ALU operation used by the
// immediate-arithmetic group.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWR   = 4'd4,
    S_MEMWB   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_FAULT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // The ANDI/ORI/BNE group is only legal when the extension is built in.
  function automatic logic opSupported(input logic [5:0] op, input logic extEn);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_BNE, OP_ANDI, OP_ORI:                   ok = extEn;
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Logical immediates use AND/OR with zero extension; ADDI adds sign-extended.
  function automatic logic [2:0] immAluop(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ANDI: code = ALUOP_AND;
      OP_ORI:  code = ALUOP_OR;
      default: code = ALUOP_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
// Bundles the opcode/memory handshake inputs and every datapath control
// output of the main control FSM.
//   master : the controller (drives mem_req and all enables/selects)
//   slave  : the datapath/memory side (drives op and mem_ready)
interface mc_control_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       branch;
  logic       branchne;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       immext;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       illegal_op;
  logic       fault;

  modport master (
    input  op, mem_ready,
    output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           branchne, iord, memtoreg, regdst, immext, alusrcb, pcsrc, aluop,
           illegal_op, fault
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           branchne, iord, memtoreg, regdst, immext, alusrcb, pcsrc, aluop,
           illegal_op, fault
  );
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// mc_mem_wait_timer
// Counts cycles a memory state has waited without mem_ready and flags the
// cycle in which the wait budget is exhausted.
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-high, count -> 0
//   clr     in  controller is changing state this cycle
//   inc     in  controller sits in a memory state
//   ready   in  memory completes this cycle
//   timeout out count has reached TIMEOUT and memory is still not ready
module mc_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // The count restarts whenever the controller moves on, and saturates at
  // TIMEOUT so a stuck wait can never wrap back into a legal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (inc && !ready && (r_count != W'(TIMEOUT)))
      r_count <= r_count + 1'b1;
  end

  // A ready arriving on the last allowed cycle still counts as completion.
  assign timeout = !ready && (r_count == W'(TIMEOUT));
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Main control FSM of the multi-cycle MIPS datapath. Decodes the IR opcode
// into datapath enables and mux selects, waits on the memory handshake and
// parks in FAULT if a memory access never completes.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high; state -> FETCH, outputs forced low
//   bus    master side of mc_control_fsm_if (op, mem_ready in; controls out)
// Parameters: MEM_HANDSHAKE (wait on mem_ready), TIMEOUT (1..255 wait cycles
// before FAULT), EN_EXT (ANDI/ORI/BNE decode).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 16,
  parameter int EN_EXT        = 1
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);
  state_t     r_state;
  state_t     w_next;
  logic       w_done;
  logic       w_timeout;
  logic       w_legal;
  logic [2:0] w_immAluop;
  logic       w_immExt;

  // Without the handshake every memory access is treated as single-cycle.
  assign w_done     = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign w_legal    = opSupported(bus.op, EN_EXT != 0);
  assign w_immAluop = immAluop(bus.op);
  assign w_immExt   = (bus.op == OP_ANDI) || (bus.op == OP_ORI);

  // The wait timer only exists when memory can stall us.
  generate
    if (MEM_HANDSHAKE != 0) begin : g_timer
      logic w_memState;
      assign w_memState = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);
      mc_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_next != r_state),
        .inc     (w_memState),
        .ready   (bus.mem_ready),
        .timeout (w_timeout)
      );
    end else begin : g_noTimer
      assign w_timeout = 1'b0;
    end
  endgenerate

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  // Next-state decode. Memory states hold until completion or timeout; the
  // opcode is read directly because the IR is stable after FETCH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_done)         w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_legal) begin
          case (bus.op)
            OP_LW, OP_SW:            w_next = S_MEMADR;
            OP_R:                    w_next = S_EXECUTE;
            OP_BEQ, OP_BNE:          w_next = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMMEX;
            OP_J:                    w_next = S_JUMP;
            default:                 w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      w_next = S_MEMRD;
        else if (bus.op == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD: begin
        if (w_done)         w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWR: begin
        if (w_done)         w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_EXECUTE: w_next = S_ALUWB;
      S_IMMEX:   w_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: w_next = S_FETCH;
      S_FAULT:   w_next = S_FAULT;
      default:   w_next = S_FETCH;
    endcase
  end

  // Output decode. Reset forces everything low so an interrupted access
  // cannot leave a request or write enable asserted. pcwrite/irwrite in
  // FETCH wait for the completing cycle; memwrite is held for the whole wait.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.branch     = 1'b0;
    bus.branchne   = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.immext     = 1'b0;
    bus.alusrcb    = SRCB_B;
    bus.pcsrc      = PCSRC_ALU;
    bus.aluop      = ALUOP_ADD;
    bus.illegal_op = 1'b0;
    bus.fault      = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcb = SRCB_FOUR;
          bus.pcwrite = w_done;
          bus.irwrite = w_done;
        end
        S_DECODE: begin
          bus.alusrcb    = SRCB_IMMSH;
          bus.illegal_op = !w_legal;
        end
        S_MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = SRCB_IMM;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
        end
        S_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        S_EXECUTE: begin
          bus.alusrca = 1'b1;
          bus.aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alusrca  = 1'b1;
          bus.aluop    = ALUOP_SUB;
          bus.pcsrc    = PCSRC_ALUOUT;
          bus.branch   = (bus.op == OP_BEQ);
          bus.branchne = (bus.op == OP_BNE);
        end
        S_IMMEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = SRCB_IMM;
          bus.aluop   = w_immAluop;
          bus.immext  = w_immExt;
        end
        S_IMMWB: begin
          bus.regwrite = 1'b1;
          bus.aluop    = w_immAluop;
          bus.immext   = w_immExt;
        end
        S_JUMP: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = PCSRC_JUMP;
        end
        S_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
`timescale 1ns/1ps
module tb_mc_control_fsm;
  localparam int TO = 4;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;

  typedef struct packed {
    logic       mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca;
    logic       branch, branchne, iord, memtoreg, regdst, immext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal_op, fault;
  } ctrl_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rdy;
    ctrl_t      exp;
  } beat_t;

  localparam ctrl_t Z = '0;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    totalChecks = 0;
  int    badChecks = 0;
  beat_t plan[$];
  ctrl_t seenA[$];
  ctrl_t seenB[$];
  ctrl_t obsA, obsB;

  always #5 clk = ~clk;

  mc_control_fsm_if busA();
  mc_control_fsm_if busB();

  mc_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT(TO), .EN_EXT(1)) dutA (
    .clk(clk), .reset(reset), .bus(busA));
  mc_control_fsm #(.MEM_HANDSHAKE(0), .TIMEOUT(TO), .EN_EXT(0)) dutB (
    .clk(clk), .reset(reset), .bus(busB));

  assign obsA = {busA.mem_req, busA.pcwrite, busA.memwrite, busA.irwrite,
                 busA.regwrite, busA.alusrca, busA.branch, busA.branchne,
                 busA.iord, busA.memtoreg, busA.regdst, busA.immext,
                 busA.alusrcb, busA.pcsrc, busA.aluop, busA.illegal_op, busA.fault};
  assign obsB = {busB.mem_req, busB.pcwrite, busB.memwrite, busB.irwrite,
                 busB.regwrite, busB.alusrca, busB.branch, busB.branchne,
                 busB.iord, busB.memtoreg, busB.regdst, busB.immext,
                 busB.alusrcb, busB.pcsrc, busB.aluop, busB.illegal_op, busB.fault};

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic bit legal(input logic [5:0] o, input bit ext);
    case (o)
      LW, SW, RT, BEQ, ADDI, JMP: return 1'b1;
      BNE, ANDI, ORI:             return ext;
      default:                    return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [5:0] o, input logic r, input ctrl_t e);
    beat_t b;
    b.op = o; b.rdy = r; b.exp = e;
    plan.push_back(b);
  endtask

  // One memory access: 'waits' cycles without ready, then a completing cycle,
  // unless the wait exceeds TO, in which case the controller faults.
  task automatic planMem(input logic [5:0] o, input ctrl_t base, input int waits,
                         input bit hs, input bit isFetch, output bit ok);
    ctrl_t e;
    ok = 1'b1;
    if (!hs) begin
      e = base;
      if (isFetch) begin e.pcwrite = 1'b1; e.irwrite = 1'b1; end
      push(o, rbit(), e);
      return;
    end
    for (int i = 0; i < waits && i <= TO; i++) push(o, 1'b0, base);
    if (waits > TO) begin
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
        e = Z; e.fault = 1'b1;
        push(o, rbit(), e);
      end
      return;
    end
    e = base;
    if (isFetch) begin e.pcwrite = 1'b1; e.irwrite = 1'b1; end
    push(o, 1'b1, e);
  endtask

  // Expected control sequence of one whole instruction.
  task automatic planInstr(input logic [5:0] o, input int fw, input int mw,
                           input bit ext, input bit hs);
    ctrl_t e;
    bit    ok;
    e = Z; e.mem_req = 1'b1; e.alusrcb = 2'b01;
    planMem(o, e, fw, hs, 1'b1, ok);
    if (!ok) return;
    e = Z; e.alusrcb = 2'b11;
    if (!legal(o, ext)) begin
      e.illegal_op = 1'b1;
      push(o, rbit(), e);
      return;
    end
    push(o, rbit(), e);
    case (o)
      LW, SW: begin
        e = Z; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(o, rbit(), e);
        e = Z; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (o == SW);
        planMem(o, e, mw, hs, 1'b0, ok);
        if (ok && o == LW) begin
          e = Z; e.regwrite = 1'b1; e.memtoreg = 1'b1;
          push(o, rbit(), e);
        end
      end
      RT: begin
        e = Z; e.alusrca = 1'b1; e.aluop = 3'b010;
        push(o, rbit(), e);
        e = Z; e.regwrite = 1'b1; e.regdst = 1'b1;
        push(o, rbit(), e);
      end
      BEQ, BNE: begin
        e = Z; e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01;
        e.branch = (o == BEQ); e.branchne = (o == BNE);
        push(o, rbit(), e);
      end
      ADDI, ANDI, ORI: begin
        e = Z;
        e.aluop  = (o == ANDI) ? 3'b011 : (o == ORI) ? 3'b100 : 3'b000;
        e.immext = (o != ADDI);
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(o, rbit(), e);
        e.alusrca = 1'b0; e.alusrcb = 2'b00; e.regwrite = 1'b1;
        push(o, rbit(), e);
      end
      JMP: begin
        e = Z; e.pcwrite = 1'b1; e.pcsrc = 2'b10;
        push(o, rbit(), e);
      end
      default: ;
    endcase
  endtask

  // Called on a falling edge; drives each beat there and samples 1ns later.
  task automatic playPlan(input int n);
    int lim;
    lim = (n < 0) ? plan.size() : n;
    seenA.delete(); seenB.delete();
    for (int i = 0; i < lim; i++) begin
      busA.op = plan[i].op; busB.op = plan[i].op;
      busA.mem_ready = plan[i].rdy; busB.mem_ready = plan[i].rdy;
      #1;
      seenA.push_back(obsA);
      seenB.push_back(obsB);
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    busA.op = '0; busB.op = '0; busA.mem_ready = 1'b0; busB.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    plan.delete();
  endtask

  task automatic test_reset();
    ctrl_t e;
    reset = 1'b1;
    busA.op = '0; busB.op = '0; busA.mem_ready = 1'b0; busB.mem_ready = 1'b0;
    @(negedge clk); #1;
    totalChecks++;
    if (obsA !== Z) begin badChecks++; $display("[TB] FAIL reset_outA: got %h want %h", obsA, Z); end
    totalChecks++;
    if (obsB !== Z) begin badChecks++; $display("[TB] FAIL reset_outB: got %h want %h", obsB, Z); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    e = Z; e.mem_req = 1'b1; e.alusrcb = 2'b01;
    totalChecks++;
    if (obsA !== e) begin badChecks++; $display("[TB] FAIL reset_fetchA: got %h want %h", obsA, e); end
    e.pcwrite = 1'b1; e.irwrite = 1'b1;
    totalChecks++;
    if (obsB !== e) begin badChecks++; $display("[TB] FAIL reset_fetchB: got %h want %h", obsB, e); end
  endtask

  task automatic test_lw_stream();
    doReset();
    planInstr(LW, 0, 0, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL lw_stream beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_fetch_wait();
    doReset();
    planInstr(RT, 3, 0, 1'b1, 1'b1);
    planInstr(ADDI, TO, 0, 1'b1, 1'b1);
    planInstr(LW, 1, TO, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL fetch_wait beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_sw_timeout();
    doReset();
    planInstr(SW, 0, 99, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL sw_timeout beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
    doReset();
    planInstr(JMP, 0, 0, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL fault_recover beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_ori_ext();
    doReset();
    planInstr(ORI, 1, 0, 1'b1, 1'b1);
    planInstr(ANDI, 0, 0, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL ori_ext beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
    doReset();
    planInstr(ORI, 0, 0, 1'b0, 1'b0);
    planInstr(BNE, 0, 0, 1'b0, 1'b0);
    planInstr(ADDI, 0, 0, 1'b0, 1'b0);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenB[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL ori_noext beat %0d: got %h want %h", i, seenB[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    doReset();
    planInstr(BEQ, 0, 0, 1'b1, 1'b1);
    planInstr(BNE, 2, 0, 1'b1, 1'b1);
    planInstr(JMP, 0, 0, 1'b1, 1'b1);
    planInstr(BEQ, 1, 0, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL branch_jump beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_reset_midaccess();
    doReset();
    planInstr(LW, 0, 3, 1'b1, 1'b1);
    playPlan(5);
    for (int i = 0; i < seenA.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL mid_pre beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
    busA.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    totalChecks++;
    if (obsA !== Z) begin badChecks++; $display("[TB] FAIL mid_reset_out: got %h want %h", obsA, Z); end
    @(negedge clk);
    reset = 1'b0;
    plan.delete();
    planInstr(LW, TO, 1, 1'b1, 1'b1);
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL mid_post beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [5:0] opList [9];
    logic [5:0] o;
    opList = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};
    doReset();
    for (int k = 0; k < 30; k++) begin
      o = ($urandom_range(4, 0) == 0) ? 6'($urandom) : opList[$urandom_range(8, 0)];
      planInstr(o, $urandom_range(TO, 0), $urandom_range(TO, 0), 1'b1, 1'b1);
    end
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenA[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL random_A beat %0d: got %h want %h", i, seenA[i], plan[i].exp);
      end
    end
    doReset();
    for (int k = 0; k < 30; k++) begin
      o = ($urandom_range(4, 0) == 0) ? 6'($urandom) : opList[$urandom_range(8, 0)];
      planInstr(o, 0, 0, 1'b0, 1'b0);
    end
    playPlan(-1);
    for (int i = 0; i < plan.size(); i++) begin
      totalChecks++;
      if (seenB[i] !== plan[i].exp) begin
        badChecks++;
        $display("[TB] FAIL random_B beat %0d: got %h want %h", i, seenB[i], plan[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_stream();
    test_fetch_wait();
    test_sw_timeout();
    test_ori_ext();
    test_branch_jump();
    test_reset_midaccess();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
